alu_op_sequencer: RTL and testbench

//  Sequences one ALU operation at a time. Accepts a request (one-hot op, X, Y) over a

---
 rtl/alu_op_sequencer_pkg.sv | 30 +++
 rtl/alu_op_sequencer_if.sv | 32 +++
 rtl/alu_op_sequencer_onehot_check.sv | 14 +
 rtl/alu_op_sequencer.sv | 121 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer and its neighbours.
//   - OP_* : bit positions inside the one-hot ALU op vector
//   - state_t : sequencer FSM states (2-bit encoding)
//   - max_int : helper for sizing counters from parameters
package alu_op_sequencer_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_SHR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_ROR = 6;
  localparam int OP_ROL = 7;
  localparam int OP_AND = 8;
  localparam int OP_OR  = 9;
  localparam int OP_NEG = 10;
  localparam int OP_NOT = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus bundle between control unit, sequencer and combinational ALU.
//   master : control unit / ALU side (drives requests and alu_result)
//   slave  : the sequencer (drives ready, ALU inputs, Z and status pulses)
interface alu_op_sequencer_if #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [SIG_COUNT-1:0]  req_op;
  logic [BITS-1:0]       req_x;
  logic [BITS-1:0]       req_y;
  logic [SIG_COUNT-1:0]  alu_ctrl;
  logic [BITS-1:0]       alu_x;
  logic [BITS-1:0]       alu_y;
  logic [2*BITS-1:0]     alu_result;
  logic [BITS-1:0]       z_hi;
  logic [BITS-1:0]       z_lo;
  logic                  busy;
  logic                  done;
  logic                  op_err;

  modport master (
    output req_valid, req_op, req_x, req_y, alu_result,
    input  req_ready, alu_ctrl, alu_x, alu_y, z_hi, z_lo, busy, done, op_err
  );

  modport slave (
    input  req_valid, req_op, req_x, req_y, alu_result,
    output req_ready, alu_ctrl, alu_x, alu_y, z_hi, z_lo, busy, done, op_err
  );
endinterface

// File: rtl/alu_op_sequencer_onehot_check.sv
// onehot_check: combinational test that exactly one bit of vec is set.
//   vec       in  SIG_COUNT  vector under test
//   is_onehot out 1          1 when vec has exactly one bit set
module onehot_check #(
  parameter int SIG_COUNT = 12
) (
  input  logic [SIG_COUNT-1:0] vec,
  output logic                 is_onehot
);
  localparam logic [SIG_COUNT-1:0] ONE = {{(SIG_COUNT-1){1'b0}}, 1'b1};

  // Clearing the lowest set bit leaves zero only for single-bit vectors.
  assign is_onehot = (vec != '0) && ((vec & (vec - ONE)) == '0);
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one ALU operation at a time.
//   clock  in  rising-edge clock
//   clear  in  asynchronous active-high reset
//   bus    slave modport: request handshake (req_*), ALU drive (alu_ctrl/x/y),
//          ALU result in, captured Z (z_hi/z_lo), busy/done/op_err status.
// A one-hot request is latched, held on the ALU inputs for the op's latency,
// and the full 2*BITS result is captured into Z as done pulses. Non one-hot
// requests are consumed and flagged with a single-cycle op_err.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int SIG_COUNT     = 12,
  parameter int MULDIV_CYCLES = 4,
  parameter int SIMPLE_CYCLES = 1
) (
  input  logic              clock,
  input  logic              clear,
  alu_op_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(max_int(MULDIV_CYCLES, SIMPLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SIMPLE_LOAD = CNT_W'(SIMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [SIG_COUNT-1:0] op_reg, op_next;
  logic [BITS-1:0]      x_reg, x_next;
  logic [BITS-1:0]      y_reg, y_next;
  logic [BITS-1:0]      z_hi_reg, z_hi_next;
  logic [BITS-1:0]      z_lo_reg, z_lo_next;
  logic                 op_err_reg, op_err_next;
  logic                 op_ok;
  logic                 handshake;

  onehot_check #(.SIG_COUNT(SIG_COUNT)) u_onehot (
    .vec       (bus.req_op),
    .is_onehot (op_ok)
  );

  // req_ready is decoded from the state register only, so the handshake
  // never depends combinationally on the requester.
  assign handshake = bus.req_valid && (state_reg == S_IDLE);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      op_reg     <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      z_hi_reg   <= '0;
      z_lo_reg   <= '0;
      op_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      op_reg     <= op_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      z_hi_reg   <= z_hi_next;
      z_lo_reg   <= z_lo_next;
      op_err_reg <= op_err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    op_next     = op_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    z_hi_next   = z_hi_reg;
    z_lo_next   = z_lo_reg;
    op_err_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (handshake) begin
          if (op_ok) begin
            op_next    = bus.req_op;
            x_next     = bus.req_x;
            y_next     = bus.req_y;
            cnt_next   = (bus.req_op[OP_MUL] || bus.req_op[OP_DIV]) ? MULDIV_LOAD : SIMPLE_LOAD;
            state_next = S_EXEC;
          end else begin
            op_err_next = 1'b1;
          end
        end
      end
      S_EXEC: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - CNT_ONE;
        end else begin
          // Last hold cycle: ALU inputs have been stable long enough.
          z_hi_next  = bus.alu_result[2*BITS-1:BITS];
          z_lo_next  = bus.alu_result[BITS-1:0];
          op_next    = '0;
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.op_err    = op_err_reg;
  assign bus.alu_ctrl  = op_reg;
  assign bus.alu_x     = x_reg;
  assign bus.alu_y     = y_reg;
  assign bus.z_hi      = z_hi_reg;
  assign bus.z_lo      = z_lo_reg;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU and a
// request-level model of the expected Z, latency and status pulses.
module tb_alu_op_sequencer;
  localparam int BITS = 32;
  localparam int SC   = 12;
  localparam int MD   = 4;
  localparam int SI   = 1;

  logic clock;
  logic clear;
  int   n_total;
  int   n_bad;
  logic [63:0] z_exp;

  alu_op_sequencer_if #(.BITS(BITS), .SIG_COUNT(SC)) bus ();

  alu_op_sequencer #(
    .BITS(BITS), .SIG_COUNT(SC), .MULDIV_CYCLES(MD), .SIMPLE_CYCLES(SI)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: result of a one-hot op; anything else yields zero.
  function automatic logic [63:0] alu_fn(input logic [11:0] op, input logic [31:0] x, input logic [31:0] y);
    int idx;
    logic [63:0] xx;
    logic [4:0]  s;
    idx = -1;
    if ($countones(op) == 1)
      for (int i = 0; i < 12; i++) if (op[i]) idx = i;
    xx = {x, x};
    s  = y[4:0];
    case (idx)
      0:  return {32'd0, x + y};
      1:  return {32'd0, x - y};
      2:  return 64'(x) * 64'(y);
      3:  return (y == 0) ? 64'd0 : {x % y, x / y};
      4:  return {32'd0, x >> s};
      5:  return {32'd0, x << s};
      6:  begin xx = xx >> s; return {32'd0, xx[31:0]}; end
      7:  begin xx = xx << s; return {32'd0, xx[63:32]}; end
      8:  return {32'd0, x & y};
      9:  return {32'd0, x | y};
      10: return {32'd0, -x};
      11: return {32'd0, ~x};
      default: return 64'd0;
    endcase
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_ctrl, bus.alu_x, bus.alu_y);

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int op_latency(input logic [11:0] op);
    return (op[2] || op[3]) ? MD + 1 : SI + 1;
  endfunction

  // Present a request at a negedge and return on the negedge after its handshake.
  task automatic send(input logic [11:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_x     = x;
    bus.req_y     = y;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check_val("ready_timeout", 64'(bus.req_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_op(input logic [11:0] op, input logic [31:0] x, input logic [31:0] y);
    int lat;
    lat = op_latency(op);
    send(op, x, y);
    bus.req_valid = 1'b0;
    if ($countones(op) == 1) begin
      for (int k = 1; k <= lat; k++) begin
        if (k > 1) @(negedge clock);
        if (k < lat) begin
          check_val("exec_ctrl", 64'(bus.alu_ctrl), 64'(op));
          check_val("exec_x", 64'(bus.alu_x), 64'(x));
          check_val("exec_y", 64'(bus.alu_y), 64'(y));
          check_val("exec_ready", 64'(bus.req_ready), 64'd0);
          check_val("exec_done", 64'(bus.done), 64'd0);
        end else begin
          z_exp = alu_fn(op, x, y);
          check_val("done_hi", 64'(bus.done), 64'd1);
          check_val("done_busy", 64'(bus.busy), 64'd1);
          check_val("z_capture", {bus.z_hi, bus.z_lo}, z_exp);
        end
      end
      @(negedge clock);
      check_val("done_pulse", 64'(bus.done), 64'd0);
      check_val("idle_ready", 64'(bus.req_ready), 64'd1);
      check_val("idle_ctrl", 64'(bus.alu_ctrl), 64'd0);
    end else begin
      check_val("op_err", 64'(bus.op_err), 64'd1);
      check_val("err_ready", 64'(bus.req_ready), 64'd1);
      check_val("err_busy", 64'(bus.busy), 64'd0);
      check_val("err_z_hold", {bus.z_hi, bus.z_lo}, z_exp);
      @(negedge clock);
      check_val("op_err_pulse", 64'(bus.op_err), 64'd0);
    end
  endtask

  initial begin
    logic [11:0] op;
    logic [11:0] one;
    logic [31:0] x;
    logic [31:0] y;
    int d1;
    int d2;
    int p;
    int r;

    n_total = 0;
    n_bad   = 0;
    z_exp   = 64'd0;
    one     = 12'd1;
    clear   = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;

    // Reset state
    repeat (2) @(negedge clock);
    check_val("rst_z", {bus.z_hi, bus.z_lo}, 64'd0);
    check_val("rst_ctrl", 64'(bus.alu_ctrl), 64'd0);
    check_val("rst_x", 64'(bus.alu_x), 64'd0);
    check_val("rst_status", {61'd0, bus.done, bus.op_err, bus.busy}, 64'd0);
    clear = 1'b0;
    @(negedge clock);
    check_val("rst_ready", 64'(bus.req_ready), 64'd1);

    // 1: add
    run_op(12'h001, 32'd5, 32'd7);
    check_val("add_zlo", 64'(bus.z_lo), 64'd12);
    // 2: mul with carry into z_hi
    run_op(12'h004, 32'h10000, 32'h10000);
    check_val("mul_zhi", 64'(bus.z_hi), 64'd1);
    check_val("mul_zlo", 64'(bus.z_lo), 64'd0);
    // 3: bad ops
    run_op(12'h003, 32'd1, 32'd2);
    run_op(12'h000, 32'd3, 32'd4);

    // 4: add held during a div is accepted only after the div completes
    d1 = MD + 1;
    d2 = d1 + SI + 2;
    send(12'h008, 32'd100, 32'd7);
    bus.req_op = 12'h001;
    bus.req_x  = 32'd40;
    bus.req_y  = 32'd2;
    for (int k = 1; k <= d2 + 1; k++) begin
      if (k > 1) @(negedge clock);
      if (k == d1 + 2) bus.req_valid = 1'b0;
      check_val("busy_done", 64'(bus.done), 64'((k == d1) || (k == d2)));
      if (k < d1) check_val("busy_ctrl", 64'(bus.alu_ctrl), 64'h008);
      if (k == d1) check_val("busy_div_z", {bus.z_hi, bus.z_lo}, {32'd2, 32'd14});
    end
    z_exp = 64'd42;
    check_val("busy_final_z", {bus.z_hi, bus.z_lo}, z_exp);

    // 5: clear during the second EXEC cycle of a mul
    send(12'h004, 32'd9, 32'd9);
    bus.req_valid = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    #1;
    check_val("clr_z", {bus.z_hi, bus.z_lo}, 64'd0);
    check_val("clr_alu", {20'd0, bus.alu_ctrl, bus.alu_x}, 64'd0);
    check_val("clr_status", {61'd0, bus.done, bus.op_err, bus.busy}, 64'd0);
    @(negedge clock);
    clear = 1'b0;
    z_exp = 64'd0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check_val("clr_no_done", 64'(bus.done), 64'd0);
    end
    run_op(12'h001, 32'd1000, 32'd234);

    // 6: three back-to-back adds with req_valid held
    p = SI + 2;
    send(12'h001, 32'd11, 32'd22);
    for (int k = 1; k <= 3 * p; k++) begin
      if (k > 1) @(negedge clock);
      if (k == 2 * p + 1) bus.req_valid = 1'b0;
      check_val("b2b_done", 64'(bus.done), 64'(((k - (SI + 1)) % p == 0) && (k >= SI + 1) && (k <= SI + 1 + 2 * p)));
    end
    z_exp = 64'd33;
    check_val("b2b_z", {bus.z_hi, bus.z_lo}, z_exp);

    // Randomized ops, including some malformed op vectors
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 12) op = one << r;
      else        op = 12'($urandom);
      x = $urandom;
      y = (r == 3 && ($urandom_range(0, 3) == 0)) ? 32'd0 : $urandom;
      run_op(op, x, y);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
